uart_tx_port: RTL and testbench
===============================

# uart_tx_port

Byte-wide transmit port that lets the CPU core stream data off-chip over a UART line. Sits directly downstream of the core's decoder/register write path. The core issues one-cycle byte writes, which are buffered in a small FIFO. A baud-rate serializer drains the FIFO onto the `tx` pin as 8N1 frames, or 8E1 frames when parity is enabled.

## Interface
- `CLK_HZ`, default 27_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate; divisor `DIV = CLK_HZ / BAUD`, truncating; `DIV` must be ≥ 2.
- `FIFO_DEPTH`, default 16: FIFO entries; must be a power of two, ≥ 2.
- `clk  in  1`: system clock; all logic is on the rising edge.
- `rst  in  1`: reset; synchronous, active-low.
- `w_enable  in  1`: one-cycle byte write strobe from the core.
- `w_data  in  8`: byte written when `w_enable`=1.
- `full  out  1`: FIFO holds `FIFO_DEPTH` entries.
- `empty  out  1`: FIFO holds 0 entries.
- `count  out  $clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `overflow  out  1`: sticky flag; set when a write is dropped.
- `busy  out  1`: serializer is not in IDLE.
- `tx  out  1`: serial line; idles high.

## Operation
- **Reset** (`rst`=0 at an edge):
  - FIFO pointers and `count` go to 0, `empty`=1, `full`=0, `overflow`=0.
  - State goes to IDLE, `busy`=0, `tx`=1.
  - Any frame in progress is abandoned and not resumed.
- **Write path:**
  - With `w_enable`=1 and `full`=0, `w_data` is pushed at that edge.
  - With `w_enable`=1 and `full`=1, the byte is dropped and `overflow` is set.
  - `full` is sampled before any same-cycle pop. A write to a full FIFO is dropped even if a pop happens in that cycle.
- **Pop:**
  - Only in IDLE with `empty`=0. The head byte is loaded into the shift register at that edge.
  - A same-cycle write and pop leave `count` unchanged.
  - A write to an empty FIFO is never popped in the same cycle.
- **States:**
  - IDLE: moves to START on pop.
  - START: `tx`=0 for `DIV` cycles, then DATA.
  - DATA: 8 bits, LSB first, `DIV` cycles each; after bit 7, goes to PARITY if enabled, otherwise STOP.
  - PARITY: the parity bit for `DIV` cycles, then STOP.
  - STOP: `tx`=1 for `DIV` cycles, then IDLE.
- **Baud counter:**
  - Loads `DIV-1` on each state or bit entry, counts down, and advances at 0.
  - Counter width is `$clog2(DIV)`.
  - Bit index is 3 bits and wraps 7→0 only on leaving DATA.
- **Back-to-back frames:** the IDLE cycle between STOP and the next START is allowed, so consecutive frames are `frame_bits*DIV + 1` cycles apart.
- **Outputs:** `tx` is driven from a register and is glitch-free.

## Timing
- Write sampled at edge k into an empty FIFO while IDLE:
  - The pop occurs at edge k+1.
  - `tx` falls after edge k+1.
  - `busy`=1 after edge k+1.
- Start bit spans edges k+1 to k+1+`DIV`. Data bit i begins at edge k+1+(i+1)·`DIV`.
- `count`, `full` and `empty` update at the same edge as the push or pop.
- `overflow` rises at the edge of the dropped write. It is cleared only by reset.
- Frame length is 10·`DIV` cycles without parity and 11·`DIV` cycles with parity.

## Configuration
- Macro `UART_TX_PARITY_EN`:
  - Defined: the PARITY state is compiled in. The parity bit is even parity, the XOR of the 8 data bits, sent after bit 7. Frames are 11 bits.
  - Undefined: the PARITY state and its logic are absent, DATA goes directly to STOP, and frames are 10 bits (8N1).

## Structure
- The shared package `uart_pkg` holds the state encoding (typedef `uart_tx_state_t`: IDLE, START, DATA, PARITY, STOP) and the framing constants `UART_DATA_BITS`=8, `UART_START_LVL`=0 and `UART_STOP_LVL`=1.
- One sub-module, `uart_tx_fifo`:
  - Synchronous FIFO, 8 bits wide, depth `FIFO_DEPTH`.
  - Holds the pointers, `count`, `full`, `empty` and the overflow logic.
  - Read data is available combinationally at the head.
- The serializer FSM and baud counter live in `uart_tx_port`.

## Test plan
All scenarios use `CLK_HZ`=1_000_000, `BAUD`=100_000 (`DIV`=10) and `FIFO_DEPTH`=4.
1. Reset then idle for 50 cycles → `tx`=1, `busy`=0, `empty`=1, `count`=0, `overflow`=0.
2. Write 0xA5 at edge k → `tx` low from k+1. Bits sampled at mid-bit are 1,0,1,0,0,1,0,1, then stop=1. `busy` drops at k+1+100 (8N1).
3. Write 0x01, 0x02, 0x03 on consecutive cycles → `count` goes 1,2,3 and then drops as bytes pop. The three frames appear in order, each starting 101 cycles after the previous one.
4. Write 6 bytes on consecutive cycles while IDLE → bytes 1–5 are stored (the first is popped at once), byte 6 is dropped, and `overflow`=1 until reset.
5. Assert `rst`=0 during data bit 3 of a frame with 2 bytes queued → at the next edge `tx`=1, `busy`=0, `count`=0. No further frames are sent.
6. With `UART_TX_PARITY_EN` defined, write 0x07 → the parity bit is 1 and the frame is 110 cycles. Write 0x03 → the parity bit is 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared UART transmit definitions: serializer state encoding and the
//   framing constants (data bits per frame, start and stop line levels).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Synchronous byte FIFO feeding the UART serializer. The head entry is
//   presented combinationally on rd_data. Writes to a full FIFO are dropped
//   and latch the sticky overflow flag until reset.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active low
//   w_enable  in   write strobe
//   w_data    in   byte to write
//   rd_en     in   pop the head entry (ignored when empty)
//   rd_data   out  head entry
//   full      out  FIFO holds FIFO_DEPTH entries
//   empty     out  FIFO holds no entries
//   count     out  current occupancy
//   overflow  out  sticky dropped-write flag
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          w_enable,
    input  logic [7:0]                    w_data,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // full is taken from the registered count, so a write to a full FIFO is
    // dropped even when a pop frees a slot on the same edge.
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = w_enable & ~w_full;
    assign w_pop   = rd_en & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_enable && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rd_data  = r_mem[r_rd_ptr];
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port
//   Byte-wide UART transmit port. Core writes are queued in uart_tx_fifo and
//   drained by a baud-rate serializer onto tx as 8N1 frames, or 8E1 frames
//   when the macro UART_TX_PARITY_EN is defined (even parity bit after bit 7).
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active low; abandons any frame
//   w_enable  in   one-cycle byte write strobe
//   w_data    in   byte written when w_enable=1
//   full      out  FIFO full
//   empty     out  FIFO empty
//   count     out  FIFO occupancy
//   overflow  out  sticky flag, a write was dropped
//   busy      out  serializer not idle
//   tx        out  registered serial line, idles high
module uart_tx_port
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 27_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          w_enable,
    input  logic [7:0]                    w_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx
);

    localparam int                DIV      = CLK_HZ / BAUD;
    localparam int                CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DIV - 1);
    localparam logic [2:0]        LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t   r_state;
    uart_tx_state_t   w_state_nxt;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_tx;
    logic             w_tx_nxt;
    logic             w_pop;
    logic [7:0]       w_rd_data;
    logic             w_empty;
`ifdef UART_TX_PARITY_EN
    logic             r_parity;
    logic             w_parity_nxt;
`endif

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .w_enable (w_enable),
        .w_data   (w_data),
        .rd_en    (w_pop),
        .rd_data  (w_rd_data),
        .full     (full),
        .empty    (w_empty),
        .count    (count),
        .overflow (overflow)
    );

    // Control state: FSM, baud counter, bit index and the tx line register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx       <= UART_STOP_LVL;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_cnt_nxt;
            r_bit_idx  <= w_idx_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // Shift data carries no reset; it is always reloaded on a pop.
    always_ff @(posedge clk) begin
        r_shift  <= w_shift_nxt;
`ifdef UART_TX_PARITY_EN
        r_parity <= w_parity_nxt;
`endif
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_baud_cnt;
        w_idx_nxt    = r_bit_idx;
        w_shift_nxt  = r_shift;
        w_tx_nxt     = r_tx;
        w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            IDLE: begin
                // empty is registered, so a byte written this cycle is only
                // seen (and popped) on the following edge.
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                    w_cnt_nxt   = CNT_LOAD;
                    w_tx_nxt    = UART_START_LVL;
                    w_shift_nxt = w_rd_data;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = ^w_rd_data;
`endif
                end
            end
            START: begin
                if (r_baud_cnt == '0) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = CNT_LOAD;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_cnt_nxt = r_baud_cnt - CNT_W'(1);
                end
            end
            DATA: begin
                if (r_baud_cnt == '0) begin
                    w_cnt_nxt = CNT_LOAD;
                    if (r_bit_idx == LAST_BIT) begin
                        w_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = STOP;
                        w_tx_nxt    = UART_STOP_LVL;
`endif
                    end else begin
                        // The line always shows r_shift[0]; shifting right
                        // exposes the next bit, LSB first.
                        w_idx_nxt   = r_bit_idx + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_baud_cnt - CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (r_baud_cnt == '0) begin
                    w_state_nxt = STOP;
                    w_cnt_nxt   = CNT_LOAD;
                    w_tx_nxt    = UART_STOP_LVL;
                end else begin
                    w_cnt_nxt = r_baud_cnt - CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (r_baud_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_baud_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = UART_STOP_LVL;
            end
        endcase
    end

    assign empty = w_empty;
    assign busy  = (r_state != IDLE);
    assign tx    = r_tx;

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port
//   Directed bench for uart_tx_port with DIV=10 and a 4-entry FIFO.
//   Parity scenarios are included when UART_TX_PARITY_EN is defined.
module tb_uart_tx_port;

    localparam int CLK_HZ     = 1_000_000;
    localparam int BAUD       = 100_000;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_enable = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       busy;
    logic       tx;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_port #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .w_enable (w_enable),
        .w_data   (w_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .busy     (busy),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        w_enable = 1'b1;
        w_data   = d;
        tick(1);
        w_enable = 1'b0;
    endtask

    // Entered 'elapsed' cycles after the pop edge s; returns just after edge
    // s + 10*FB, where busy has dropped.
    task automatic check_frame(input logic [7:0] d, input int elapsed, input string tag);
        check({tag, "_start"}, {31'd0, tx}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        tick(5 - elapsed);
        check({tag, "_startmid"}, {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(10);
            check($sformatf("%s_bit%0d", tag, i), {31'd0, tx}, {31'd0, d[i]});
        end
`ifdef UART_TX_PARITY_EN
        tick(10);
        check({tag, "_parity"}, {31'd0, tx}, {31'd0, ^d});
`endif
        tick(10);
        check({tag, "_stop"}, {31'd0, tx}, 32'd1);
        tick(4);
        check({tag, "_busy_last"}, {31'd0, busy}, 32'd1);
        tick(1);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_tx_idle"}, {31'd0, tx}, 32'd1);
    endtask

    initial begin
        int exp_cnt [6];
        int lows;

        // Reset then idle
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(50);
        check("idle_tx", {31'd0, tx}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_empty", {31'd0, empty}, 32'd1);
        check("idle_full", {31'd0, full}, 32'd0);
        check("idle_count", {29'd0, count}, 32'd0);
        check("idle_ovf", {31'd0, overflow}, 32'd0);

        // Single frame 0xA5
        write_byte(8'hA5);
        check("a5_count_k", {29'd0, count}, 32'd1);
        check("a5_tx_k", {31'd0, tx}, 32'd1);
        check("a5_busy_k", {31'd0, busy}, 32'd0);
        tick(1);
        check("a5_count_k1", {29'd0, count}, 32'd0);
        check("a5_empty_k1", {31'd0, empty}, 32'd1);
        check_frame(8'hA5, 0, "a5");

        // All-ones and all-zeros data patterns
        write_byte(8'hFF);
        tick(1);
        check_frame(8'hFF, 0, "ff");
        write_byte(8'h00);
        tick(1);
        check_frame(8'h00, 0, "00");

        // Three consecutive writes; first pops one edge after it is written
        write_byte(8'h01);
        check("q3_count0", {29'd0, count}, 32'd1);
        w_enable = 1'b1;
        w_data   = 8'h02;
        tick(1);
        check("q3_count1", {29'd0, count}, 32'd1);
        w_data   = 8'h03;
        tick(1);
        w_enable = 1'b0;
        check("q3_count2", {29'd0, count}, 32'd2);
        check_frame(8'h01, 1, "q3_f1");
        tick(1);
        check("q3_count_pop2", {29'd0, count}, 32'd1);
        check_frame(8'h02, 0, "q3_f2");
        tick(1);
        check("q3_count_pop3", {29'd0, count}, 32'd0);
        check_frame(8'h03, 0, "q3_f3");
        tick(20);
        check("q3_quiet_busy", {31'd0, busy}, 32'd0);

        // Six consecutive writes: five stored, sixth dropped
        exp_cnt = '{1, 1, 2, 3, 4, 4};
        for (int i = 0; i < 6; i++) begin
            w_enable = 1'b1;
            w_data   = 8'(8'h10 + i);
            tick(1);
            check($sformatf("ovf_count%0d", i), {29'd0, count}, 32'(exp_cnt[i]));
            if (i == 4) begin
                check("ovf_full4", {31'd0, full}, 32'd1);
                check("ovf_flag4", {31'd0, overflow}, 32'd0);
            end
        end
        w_enable = 1'b0;
        check("ovf_full5", {31'd0, full}, 32'd1);
        check("ovf_flag5", {31'd0, overflow}, 32'd1);
        check_frame(8'h10, 4, "ovf_f0");
        for (int i = 1; i < 5; i++) begin
            tick(1);
            check_frame(8'(8'h10 + i), 0, $sformatf("ovf_f%0d", i));
        end
        tick(20);
        check("ovf_empty", {31'd0, empty}, 32'd1);
        check("ovf_nomore", {31'd0, busy}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset in data bit 3 with two bytes queued
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        check("rst_ovf_clr", {31'd0, overflow}, 32'd0);
        write_byte(8'h5A);
        w_enable = 1'b1;
        w_data   = 8'h33;
        tick(1);
        w_data   = 8'hCC;
        tick(1);
        w_enable = 1'b0;
        check("rst_count_q", {29'd0, count}, 32'd2);
        tick(44);
        check("rst_bit3", {31'd0, tx}, 32'd1);
        check("rst_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        tick(1);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        rst = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("rst_no_resume", 32'(lows), 32'd0);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0; frame is 110 cycles
        write_byte(8'h07);
        tick(1);
        check_frame(8'h07, 0, "par07");
        write_byte(8'h03);
        tick(1);
        check_frame(8'h03, 0, "par03");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
